rom_port_arbiter: RTL and testbench
===================================

Name: rom_port_arbiter

Overview:
Shares the single read port of the instruction/constant ROM between two requesters: the instruction-fetch port (I) and the load unit's data port (D).
- Arbitrates valid/ready requests and drives the ROM address, size and enable.
- Captures the ROM's one-cycle-latency read data and its misalignment exception into a per-port response register.
- Holds each response until the requester accepts it.
- Sits between the fetch/LSU stages and the ROM inside the CPU core.

Parameters:
ADDR_W, 8, ROM byte-address width (ROM word-index bits + 2 + 1; 8 matches a 32-word ROM).
I_SIZE, 3'b010, access size the I port always issues (word).

Ports:
CLK  in  1  clock; all state updates on rising edge.
reset  in  1  synchronous, active-low reset (0 = reset, sampled on CLK rising edge).
i_req_valid  in  1  fetch request valid.
i_req_ready  out  1  fetch request accepted this cycle.
i_req_addr  in  ADDR_W  fetch byte address.
i_rsp_valid  out  1  fetch response held valid.
i_rsp_ready  in  1  fetch consumer takes response.
i_rsp_data  out  32  fetched word.
i_rsp_err  out  1  fetch caused ROM misalignment exception.
d_req_valid  in  1  load request valid.
d_req_ready  out  1  load request accepted this cycle.
d_req_addr  in  ADDR_W  load byte address.
d_req_size  in  3  load size code (000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu).
d_rsp_valid  out  1  load response held valid.
d_rsp_ready  in  1  load consumer takes response.
d_rsp_data  out  32  extended load data from ROM.
d_rsp_err  out  1  load caused ROM exception.
rom_addr  out  ADDR_W  ROM address (registered into ROM on CLK).
rom_size  out  3  ROM size code.
rom_en  out  1  ROM access enable (qualifies exception).
rom_data  in  32  ROM data, valid the cycle after the address was presented.
rom_exc  in  1  ROM exception, combinational on the current rom_addr/rom_size/rom_en.

Behaviour:
- Per-port response slot state, one per port: EMPTY, INFLIGHT, FULL.
- Port eligible for grant when its slot is EMPTY, or FULL with rsp_ready=1 this cycle. Such a FULL slot frees and re-grants in the same cycle.
- Grant: at most one port per cycle. The granted port sees req_ready=1 combinationally; handshake = req_valid & req_ready. A non-eligible or losing port gets req_ready=0 and must hold its request stable.
- Grant cycle outputs:
  - rom_addr = winner address; rom_size = I_SIZE for I, d_req_size for D; rom_en = 1.
  - rom_exc is sampled that cycle into the winner's err bit.
  - Winner slot goes to INFLIGHT.
- No-grant cycle: rom_en=0, rom_addr/rom_size hold their previous values.
- Cycle after grant: rom_data is captured into the winner's data register; slot INFLIGHT -> FULL; rsp_valid=1 from then until the rsp_valid & rsp_ready handshake (FULL -> EMPTY).
- Latency: req handshake at cycle N -> rsp_valid at N+1 earliest. Back-to-back grants to alternating or same port are legal, giving sustained 1 access/cycle.
- Error response: rsp_err=1 with rsp_data forced to 0; otherwise rsp_err=0.
- Priority (macro off): D beats I when both are eligible and valid.
- Slot data and err registers are stable while FULL.
- Reset (reset=0 at an edge):
  - Both slots EMPTY; rsp_valid=0, rsp_err=0, rsp_data=0.
  - rom_en=0, rom_addr=0, rom_size=3'b010.
  - Round-robin pointer favours I.
  - An INFLIGHT access at reset is discarded and never produces a response.
  - req_ready=0 while reset=0.

Optional Feature:
ROM_ARB_ROUND_ROBIN_EN
- Defined: round-robin between I and D. A 1-bit last_grant register is updated on each grant; on contention, the port not granted last wins. Reset sets last_grant = D, so I wins the first tie.
- Undefined: fixed priority, D over I. No last_grant register is synthesized.

Test Plan:
1. Reset held low 2 cycles with both req_valid=1 -> req_ready=0, rom_en=0, rsp_valid=0; first cycle after release grants one port per the priority rule.
2. Single I fetch addr 0x04 with ROM word1=0xDEADBEEF -> i_req_ready=1 at N, i_rsp_valid=1 at N+1 with data 0xDEADBEEF, err=0; hold i_rsp_ready=0 for 3 cycles -> data stable.
3. Simultaneous I (0x00) and D (0x08, size 010) requests, macro off -> D granted at N, I at N+1; d_rsp at N+1, i_rsp at N+2.
4. Same contention repeated 4 cycles, macro on -> grants alternate I, D, I, D.
5. D load addr 0x05 size 010 -> d_rsp_err=1, d_rsp_data=0; I request in the next cycle proceeds normally.
6. Reset asserted the cycle after a D grant -> d_rsp_valid never asserts; after release, a new D request returns correct data.

Source files
------------

// File: rtl/rom_port_arbiter.sv
// rom_port_arbiter: shares the ROM read port between fetch (I) and load (D); define ROM_ARB_ROUND_ROBIN_EN for round-robin, else D beats I
module rom_port_arbiter #(
  parameter int         ADDR_W = 8,
  parameter logic [2:0] I_SIZE = 3'b010
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic              i_req_valid,
  output logic              i_req_ready,
  input  logic [ADDR_W-1:0] i_req_addr,
  output logic              i_rsp_valid,
  input  logic              i_rsp_ready,
  output logic [31:0]       i_rsp_data,
  output logic              i_rsp_err,
  input  logic              d_req_valid,
  output logic              d_req_ready,
  input  logic [ADDR_W-1:0] d_req_addr,
  input  logic [2:0]        d_req_size,
  output logic              d_rsp_valid,
  input  logic              d_rsp_ready,
  output logic [31:0]       d_rsp_data,
  output logic              d_rsp_err,
  output logic [ADDR_W-1:0] rom_addr,
  output logic [2:0]        rom_size,
  output logic              rom_en,
  input  logic [31:0]       rom_data,
  input  logic              rom_exc
);
  typedef enum logic [1:0] {EMPTY, INFLIGHT, FULL} slot_t;
  slot_t             r_i_st, r_d_st, w_i_st_nxt, w_d_st_nxt;
  logic              r_i_err, r_d_err;
  logic [31:0]       r_i_data, r_d_data, w_i_rdata, w_d_rdata;
  logic [ADDR_W-1:0] r_rom_addr;
  logic [2:0]        r_rom_size;
  logic              w_i_elig, w_d_elig, w_d_prio, w_gnt_i, w_gnt_d;
  // a slot can take a new access when empty or when its held response is consumed this cycle
  assign w_i_elig = reset & ((r_i_st == EMPTY) | i_rsp_ready);
  assign w_d_elig = reset & ((r_d_st == EMPTY) | d_rsp_ready);
`ifdef ROM_ARB_ROUND_ROBIN_EN
  logic r_last_d;
  // remember which port won last so a tie goes to the other one
  always_ff @(posedge CLK)
    if (!reset) r_last_d <= 1'b1;
    else if (rom_en) r_last_d <= w_gnt_d;
  assign w_d_prio = ~r_last_d;
`else
  assign w_d_prio = 1'b1;
`endif
  assign w_gnt_d = w_d_elig & d_req_valid & (~(w_i_elig & i_req_valid) | w_d_prio);
  assign w_gnt_i = w_i_elig & i_req_valid & ~w_gnt_d;
  assign i_req_ready = w_gnt_i;
  assign d_req_ready = w_gnt_d;
  assign rom_en = w_gnt_i | w_gnt_d;
  assign rom_addr = w_gnt_d ? d_req_addr : w_gnt_i ? i_req_addr : r_rom_addr;
  assign rom_size = w_gnt_d ? d_req_size : w_gnt_i ? I_SIZE : r_rom_size;
  // an erroring access returns zero data regardless of what the ROM drives
  assign w_i_rdata = r_i_err ? 32'h0 : rom_data;
  assign w_d_rdata = r_d_err ? 32'h0 : rom_data;
  // slot next state: grant starts an access, the data cycle fills or hands off, a handshake empties
  always_comb begin
    w_i_st_nxt = w_gnt_i ? INFLIGHT :
                 (r_i_st == INFLIGHT) ? (i_rsp_ready ? EMPTY : FULL) :
                 (r_i_st == FULL && i_rsp_ready) ? EMPTY : r_i_st;
    w_d_st_nxt = w_gnt_d ? INFLIGHT :
                 (r_d_st == INFLIGHT) ? (d_rsp_ready ? EMPTY : FULL) :
                 (r_d_st == FULL && d_rsp_ready) ? EMPTY : r_d_st;
  end
  // slot state, exception capture at grant and data capture in the ROM data cycle
  always_ff @(posedge CLK)
    if (!reset) begin
      r_i_st   <= EMPTY;
      r_d_st   <= EMPTY;
      r_i_err  <= 1'b0;
      r_d_err  <= 1'b0;
      r_i_data <= 32'h0;
      r_d_data <= 32'h0;
    end else begin
      r_i_st <= w_i_st_nxt;
      r_d_st <= w_d_st_nxt;
      if (w_gnt_i) r_i_err <= rom_exc;
      if (w_gnt_d) r_d_err <= rom_exc;
      if (r_i_st == INFLIGHT) r_i_data <= w_i_rdata;
      if (r_d_st == INFLIGHT) r_d_data <= w_d_rdata;
    end
  // ROM address and size hold their last driven value through idle cycles
  always_ff @(posedge CLK)
    if (!reset) begin
      r_rom_addr <= '0;
      r_rom_size <= 3'b010;
    end else begin
      r_rom_addr <= rom_addr;
      r_rom_size <= rom_size;
    end
  assign i_rsp_valid = reset & (r_i_st != EMPTY);
  assign d_rsp_valid = reset & (r_d_st != EMPTY);
  assign i_rsp_err = i_rsp_valid & r_i_err;
  assign d_rsp_err = d_rsp_valid & r_d_err;
  assign i_rsp_data = !i_rsp_valid ? 32'h0 : (r_i_st == INFLIGHT) ? w_i_rdata : r_i_data;
  assign d_rsp_data = !d_rsp_valid ? 32'h0 : (r_d_st == INFLIGHT) ? w_d_rdata : r_d_data;
endmodule

// File: tb/tb_rom_port_arbiter.sv
// tb_rom_port_arbiter: directed checks of the ROM port arbiter against a small ROM model
module tb_rom_port_arbiter;
`ifdef ROM_ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif
  logic        CLK = 1'b0, reset;
  logic        i_req_valid, i_req_ready, i_rsp_valid, i_rsp_ready, i_rsp_err;
  logic [7:0]  i_req_addr, d_req_addr, rom_addr;
  logic [31:0] i_rsp_data, d_rsp_data, rom_data;
  logic        d_req_valid, d_req_ready, d_rsp_valid, d_rsp_ready, d_rsp_err;
  logic [2:0]  d_req_size, rom_size;
  logic        rom_en, rom_exc;
  logic [31:0] mem [32];
  int          n_tests = 0, n_fail = 0;
  always #5 CLK = ~CLK;
  rom_port_arbiter dut (
    .CLK(CLK), .reset(reset),
    .i_req_valid(i_req_valid), .i_req_ready(i_req_ready), .i_req_addr(i_req_addr),
    .i_rsp_valid(i_rsp_valid), .i_rsp_ready(i_rsp_ready), .i_rsp_data(i_rsp_data), .i_rsp_err(i_rsp_err),
    .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_req_addr(d_req_addr), .d_req_size(d_req_size),
    .d_rsp_valid(d_rsp_valid), .d_rsp_ready(d_rsp_ready), .d_rsp_data(d_rsp_data), .d_rsp_err(d_rsp_err),
    .rom_addr(rom_addr), .rom_size(rom_size), .rom_en(rom_en), .rom_data(rom_data), .rom_exc(rom_exc)
  );
  // ROM model: registered word read, combinational alignment exception
  always_ff @(posedge CLK)
    if (rom_en) rom_data <= mem[rom_addr[6:2]];
  assign rom_exc = rom_en & (((rom_size[1:0] == 2'b10) & (rom_addr[1:0] != 2'b00)) |
                             ((rom_size[1:0] == 2'b01) & rom_addr[0]));
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic cyc;
    @(posedge CLK);
    #1;
  endtask
  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 32'h1000_0000 + i;
    mem[1] = 32'hDEAD_BEEF;
    mem[2] = 32'hCAFE_F00D;
    reset = 1'b0;
    i_req_valid = 1'b1; i_req_addr = 8'h00; i_rsp_ready = 1'b1;
    d_req_valid = 1'b1; d_req_addr = 8'h08; d_req_size = 3'b010; d_rsp_ready = 1'b1;
    // reset held two cycles with both requests valid
    for (int k = 0; k < 2; k++) begin
      cyc(); #1;
      check("rst_i_rdy", i_req_ready, 0);
      check("rst_d_rdy", d_req_ready, 0);
      check("rst_en", rom_en, 0);
      check("rst_i_vld", i_rsp_valid, 0);
      check("rst_d_vld", d_rsp_valid, 0);
      check("rst_addr", rom_addr, 8'h00);
      check("rst_size", rom_size, 3'b010);
      check("rst_d_data", d_rsp_data, 0);
    end
    // first cycle after release: priority winner, then the loser
    cyc(); reset = 1'b1; #1;
    check("a_i_rdy", i_req_ready, RR);
    check("a_d_rdy", d_req_ready, !RR);
    check("a_addr", rom_addr, RR ? 8'h00 : 8'h08);
    check("a_en", rom_en, 1);
    cyc(); if (RR) i_req_valid = 1'b0; else d_req_valid = 1'b0; #1;
    check("a1_i_rdy", i_req_ready, !RR);
    check("a1_d_rdy", d_req_ready, RR);
    check("a1_rsp1_vld", RR ? i_rsp_valid : d_rsp_valid, 1);
    check("a1_rsp1_data", RR ? i_rsp_data : d_rsp_data, RR ? 32'h1000_0000 : 32'hCAFE_F00D);
    cyc(); i_req_valid = 1'b0; d_req_valid = 1'b0; #1;
    check("a2_rsp2_vld", RR ? d_rsp_valid : i_rsp_valid, 1);
    check("a2_rsp2_data", RR ? d_rsp_data : i_rsp_data, RR ? 32'hCAFE_F00D : 32'h1000_0000);
    check("a2_rsp1_gone", RR ? i_rsp_valid : d_rsp_valid, 0);
    check("a2_en", rom_en, 0);
    // single fetch at 0x04, response held while the consumer stalls
    cyc(); i_rsp_ready = 1'b0; i_req_valid = 1'b1; i_req_addr = 8'h04; #1;
    check("f_rdy", i_req_ready, 1);
    check("f_addr", rom_addr, 8'h04);
    check("f_size", rom_size, 3'b010);
    cyc(); i_req_valid = 1'b0; #1;
    check("f1_vld", i_rsp_valid, 1);
    check("f1_data", i_rsp_data, 32'hDEAD_BEEF);
    check("f1_err", i_rsp_err, 0);
    for (int k = 0; k < 3; k++) begin
      cyc(); i_req_valid = 1'b1; i_req_addr = 8'h08; #1;
      check("f_hold_vld", i_rsp_valid, 1);
      check("f_hold_data", i_rsp_data, 32'hDEAD_BEEF);
      check("f_hold_rdy", i_req_ready, 0);
      check("f_hold_addr", rom_addr, 8'h04);
      check("f_hold_en", rom_en, 0);
    end
    // consuming the held response frees the slot and re-grants in the same cycle
    cyc(); i_rsp_ready = 1'b1; #1;
    check("f_regrant", i_req_ready, 1);
    check("f_regrant_addr", rom_addr, 8'h08);
    cyc(); i_req_valid = 1'b0; #1;
    check("f2_data", i_rsp_data, 32'hCAFE_F00D);
    cyc(); #1;
    check("f3_vld", i_rsp_valid, 0);
    check("f3_data", i_rsp_data, 0);
    // misaligned word load errors with zero data; fetch next cycle is unaffected
    cyc(); d_rsp_ready = 1'b0; d_req_valid = 1'b1; d_req_addr = 8'h05; d_req_size = 3'b010; #1;
    check("e_rdy", d_req_ready, 1);
    cyc(); d_req_valid = 1'b0; i_req_valid = 1'b1; i_req_addr = 8'h0C; #1;
    check("e_vld", d_rsp_valid, 1);
    check("e_err", d_rsp_err, 1);
    check("e_data", d_rsp_data, 0);
    check("e_i_rdy", i_req_ready, 1);
    check("e_i_addr", rom_addr, 8'h0C);
    cyc(); i_req_valid = 1'b0; #1;
    check("e_i_data", i_rsp_data, 32'h1000_0003);
    check("e_i_err", i_rsp_err, 0);
    check("e_hold_err", d_rsp_err, 1);
    check("e_hold_data", d_rsp_data, 0);
    cyc(); d_rsp_ready = 1'b1; #1;
    check("e_last_vld", d_rsp_valid, 1);
    cyc(); #1;
    check("e_gone_vld", d_rsp_valid, 0);
    check("e_gone_err", d_rsp_err, 0);
    // sustained contention: fixed priority keeps D, round-robin alternates (last grant was I)
    cyc(); i_req_valid = 1'b1; i_req_addr = 8'h00; d_req_valid = 1'b1; d_req_addr = 8'h08; #1;
    check("c1_d_rdy", d_req_ready, 1);
    check("c1_i_rdy", i_req_ready, 0);
    cyc(); #1;
    check("c2_d_rdy", d_req_ready, !RR);
    check("c2_i_rdy", i_req_ready, RR);
    check("c2_d_data", d_rsp_data, 32'hCAFE_F00D);
    cyc(); #1;
    check("c3_d_rdy", d_req_ready, 1);
    check("c3_i_rdy", i_req_ready, 0);
    cyc(); #1;
    check("c4_d_rdy", d_req_ready, !RR);
    check("c4_i_rdy", i_req_ready, RR);
    cyc(); i_req_valid = 1'b0; d_req_valid = 1'b0;
    cyc(); #1;
    check("c_drain_i", i_rsp_valid, 0);
    check("c_drain_d", d_rsp_valid, 0);
    // reset right after a D grant discards the access
    cyc(); d_req_valid = 1'b1; d_req_addr = 8'h08; #1;
    check("r_rdy", d_req_ready, 1);
    cyc(); d_req_valid = 1'b0; reset = 1'b0; #1;
    check("r_vld0", d_rsp_valid, 0);
    cyc(); #1;
    check("r_vld1", d_rsp_valid, 0);
    check("r_addr", rom_addr, 8'h00);
    cyc(); reset = 1'b1; #1;
    check("r_vld2", d_rsp_valid, 0);
    cyc(); d_req_valid = 1'b1; d_req_addr = 8'h04; d_req_size = 3'b101; #1;
    check("r_new_rdy", d_req_ready, 1);
    check("r_new_size", rom_size, 3'b101);
    cyc(); d_req_valid = 1'b0; #1;
    check("r_new_vld", d_rsp_valid, 1);
    check("r_new_data", d_rsp_data, 32'hDEAD_BEEF);
    check("r_new_err", d_rsp_err, 0);
    cyc();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
